// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx byte transmitter between N requesters.
// A requester owns the transmitter for a whole packet (up to req_last); an
// owner that leaves req_valid low for HOLD_CYCLES ISSUE cycles loses the lock.
//
// state    | meaning
// IDLE     | no owner; pick the next requester once tx_ready is high
// ISSUE    | owner locked; accept its next byte while tx_ready is high
// WAIT_ACK | byte strobed; wait for tx_ready low to confirm the load
module uart_tx_arbiter #(
    parameter int N           = 4,
    parameter int HOLD_CYCLES = 255
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [7:0]     tx_data,
    output logic           tx_strobe,
    input  logic           tx_ready
);
    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [15:0]   HOLD_MAX = 16'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d, ptr_adv;
    logic [IW-1:0] scan_idx, win_idx;
    logic          win_found;
    logic [15:0]   hold_q, hold_d;
    logic          last_q, last_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          strobe_q, strobe_d;
    logic          busy_q;
    logic          own_valid, own_last;
    logic [7:0]    own_data;

    assign own_valid = req_valid[owner_q];
    assign own_last  = req_last[owner_q];
    assign own_data  = req_data[{owner_q, 3'b000} +: 8];
    assign ptr_adv   = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);

    // Round-robin search starting at the pointer; explicit wrap keeps non-power-of-2 N legal.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = ptr_q;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + IW'(1);
        end
    end

    // Next-state, lock bookkeeping and the combinational accept.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        strobe_d  = 1'b0;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (tx_ready && win_found) begin
                    owner_d = win_idx;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    hold_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                req_ready[owner_q] = tx_ready;
                if (own_valid && tx_ready) begin
                    tx_data_d = own_data;
                    strobe_d  = 1'b1;
                    last_d    = own_last;
                    hold_d    = '0;
                    state_d   = WAIT_ACK;
                end else if (!own_valid) begin
                    if (hold_q >= HOLD_MAX - 16'd1) begin
                        hold_d  = HOLD_MAX;
                        grant_d = '0;
                        ptr_d   = ptr_adv;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
            end
            WAIT_ACK: begin
                if (!tx_ready) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = ptr_adv;
                        state_d = IDLE;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            last_q    <= 1'b0;
            tx_data_q <= 8'h00;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            strobe_q  <= strobe_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign tx_data   = tx_data_q;
    assign tx_strobe = strobe_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized packet traffic, checked
// against a packet-level round-robin model and a simple uart_tx busy model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int HOLD  = 4;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [8*N-1:0] req_data;
    logic           busy, tx_strobe, tx_ready;
    logic [7:0]     tx_data;

    uart_tx_arbiter #(.N(N), .HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // per-requester packet store, bit 8 = last
    logic [8:0] mem [N][DEPTH];
    int tail [N];
    int d_head [N];
    int m_head [N];
    int stall [N];
    int m_own, m_ptr;
    int stall_max, l_min, l_max;
    int busy_left;
    bit pend_load, force_low;
    logic prev_txr;
    logic [N-1:0] obs_grant, obs_rdy;
    logic obs_strobe, obs_busy;
    logic [7:0] obs_data;
    logic [7:0] slog [$];
    logic [N-1:0] g_log [40];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last);
        mem[i][tail[i]] = {last, d};
        tail[i]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            tail[i] = 0; d_head[i] = 0; m_head[i] = 0; stall[i] = 0;
        end
        m_own = -1;
        m_ptr = 0;
        req_valid = '0;
        req_last  = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_grant"},  32'(grant),     0);
        chk({tag, "_busy"},   32'(busy),      0);
        chk({tag, "_strobe"}, 32'(tx_strobe), 0);
        chk({tag, "_data"},   32'(tx_data),   0);
        chk({tag, "_ready"},  32'(req_ready), 0);
    endtask

    task automatic finish_reset();
        repeat (2) @(negedge clk);
        clear_all();
        reset = 1'b0;
    endtask

    // packet-level model: owner chosen round-robin among requesters with pending bytes
    task automatic sb_strobe();
        int pick;
        int idx;
        pick = -1;
        if (m_own < 0) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (pick < 0 && m_head[idx] < tail[idx]) pick = idx;
            end
            chk("sb_pending", 32'(pick >= 0), 1);
            m_own = pick;
        end
        if (m_own >= 0) begin
            chk("sb_owner", 32'(obs_grant), 32'(1) << m_own);
            chk("sb_byte", 32'(obs_data), 32'(mem[m_own][m_head[m_own]][7:0]));
            if (mem[m_own][m_head[m_own]][8]) begin
                m_head[m_own]++;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else begin
                m_head[m_own]++;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        obs_grant  = grant;
        obs_strobe = tx_strobe;
        obs_data   = tx_data;
        obs_busy   = busy;
        if (pend_load) begin
            busy_left = $urandom_range(l_max, l_min);
            pend_load = 1'b0;
        end
        prev_txr = tx_ready;
        tx_ready = (busy_left == 0) && !force_low;
        if (busy_left > 0) busy_left--;
        if (obs_strobe) begin
            chk("strobe_when_ready", 32'(prev_txr), 1);
            pend_load = 1'b1;
            slog.push_back(obs_data);
            sb_strobe();
        end
        for (int i = 0; i < N; i++) begin
            if (stall[i] > 0) stall[i]--;
            req_valid[i] = (d_head[i] < tail[i]) && (stall[i] == 0);
            if (req_valid[i]) begin
                req_data[i*8 +: 8] = mem[i][d_head[i]][7:0];
                req_last[i]        = mem[i][d_head[i]][8];
            end else begin
                req_data[i*8 +: 8] = 8'($urandom);
                req_last[i]        = 1'($urandom);
            end
        end
        #1;
        obs_rdy = req_ready;
        chk("rdy_owner", 32'(obs_rdy & ~obs_grant), 0);
        chk("rdy_txr", 32'((obs_rdy != '0) && !tx_ready), 0);
        chk("grant_onehot", 32'($countones(obs_grant) <= 1), 1);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && obs_rdy[i]) begin
                if (!mem[i][d_head[i]][8]) stall[i] = $urandom_range(stall_max, 0);
                d_head[i]++;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            cycle();
            done = (obs_busy == 1'b0) && (busy_left == 0) && !pend_load;
            for (int i = 0; i < N; i++) if (d_head[i] < tail[i]) done = 1'b0;
        end
        chk(tag, 32'(done), 1);
        for (int i = 0; i < N; i++) chk("sb_drained", m_head[i], tail[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, nstb, nrdy, nbad, npk, len;
        bit found;
        reset = 1'b0; tx_ready = 1'b1; req_data = '0;
        force_low = 1'b0; busy_left = 0; pend_load = 1'b0;
        stall_max = 0; l_min = 2; l_max = 2;
        clear_all();
        #2 reset = 1'b1;
        #2 check_reset("rst_init");
        finish_reset();

        // single byte 0x55 from requester 0: exact cycle timing
        push(0, 8'h55, 1'b1);
        nstb = 0; nrdy = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            g_log[k] = obs_grant;
            if (obs_rdy[0]) nrdy++;
            if (obs_strobe) nstb++;
            if (k == 2) begin
                chk("t1_strobe_c2", 32'(obs_strobe), 1);
                chk("t1_data_c2", 32'(obs_data), 32'h55);
            end
            if (k == 4) chk("t1_busy_c4", 32'(obs_busy), 0);
        end
        chk("t1_grant_c0", 32'(g_log[0]), 0);
        chk("t1_grant_c1", 32'(g_log[1]), 1);
        chk("t1_grant_c3", 32'(g_log[3]), 1);
        chk("t1_grant_c4", 32'(g_log[4]), 0);
        chk("t1_ready_cycles", nrdy, 1);
        chk("t1_strobes", nstb, 1);
        wait_idle("t1_idle", 50);

        // requester 1 three-byte packet while requester 0 stays valid (pointer now at 1)
        slog.delete();
        push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
        push(0, 8'h20, 1'b1);
        wait_idle("t2_idle", 200);
        chk("t2_count", slog.size(), 4);
        if (slog.size() == 4) begin
            chk("t2_b0", 32'(slog[0]), 32'h10);
            chk("t2_b1", 32'(slog[1]), 32'h11);
            chk("t2_b2", 32'(slog[2]), 32'h12);
            chk("t2_b3", 32'(slog[3]), 32'h20);
        end

        // all four valid, two rounds of single-byte packets: order and 3->0 wrap
        reset = 1'b1;
        finish_reset();
        slog.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(8'hA0 + i), 1'b1);
        wait_idle("t3_idle", 300);
        chk("t3_count", slog.size(), 8);
        for (int k = 0; k < 8 && k < slog.size(); k++)
            chk("t3_order", 32'(slog[k]), 32'hA0 + 32'(k % 4));

        // hold timeout: requester 1 sends a non-last byte then stalls, requester 2 waits
        push(1, 8'h31, 1'b0);
        push(2, 8'h42, 1'b1);
        s = -1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            g_log[k] = obs_grant;
            if (obs_strobe && obs_data == 8'h31) s = k;
            if (s >= 0 && k == s + 6) begin
                m_own = -1;
                m_ptr = 2;
            end
        end
        chk("t4_strobe_seen", 32'(s >= 0 && s + 7 < 40), 1);
        if (s >= 0 && s + 7 < 40) begin
            chk("t4_grant_last_issue", 32'(g_log[s+5]), 32'b0010);
            chk("t4_grant_released", 32'(g_log[s+6]), 0);
            chk("t4_grant_next", 32'(g_log[s+7]), 32'b0100);
        end
        wait_idle("t4_idle", 100);

        // tx_ready held low for 100 cycles with the owner valid mid-packet
        push(3, 8'h70, 1'b0); push(3, 8'h71, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (obs_strobe) found = 1'b1;
        end
        chk("t5_first_strobe", 32'(found), 1);
        force_low = 1'b1;
        nstb = 0; nrdy = 0; nbad = 0;
        for (int k = 0; k < 100; k++) begin
            cycle();
            if (obs_strobe) nstb++;
            if (obs_rdy != '0) nrdy++;
            if (obs_grant != 4'b1000) nbad++;
        end
        chk("t5_no_strobe", nstb, 0);
        chk("t5_no_ready", nrdy, 0);
        chk("t5_grant_held", nbad, 0);
        force_low = 1'b0;
        cycle();
        chk("t5_ready_on_release", 32'(obs_rdy), 32'b1000);
        cycle();
        chk("t5_strobe", 32'(obs_strobe), 1);
        chk("t5_data", 32'(obs_data), 32'h71);
        wait_idle("t5_idle", 100);

        // asynchronous reset in WAIT_ACK
        push(0, 8'h5A, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (obs_strobe) found = 1'b1;
        end
        chk("t6_wait_reached", 32'(found), 1);
        reset = 1'b1;
        #1 check_reset("rst_wait");
        finish_reset();

        // asynchronous reset in ISSUE with the owner being accepted
        push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (obs_grant != '0) found = 1'b1;
        end
        chk("t6_issue_reached", 32'(found), 1);
        reset = 1'b1;
        #1 check_reset("rst_issue");
        finish_reset();
        repeat (8) cycle();

        // first grant after reset goes to the lowest valid index
        push(3, 8'h83, 1'b1); push(1, 8'h81, 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (obs_grant != '0) found = 1'b1;
        end
        chk("t6_post_reset_grant", 32'(obs_grant), 32'b0010);
        wait_idle("t6_idle", 100);

        // randomized packets, owner stalls shorter than the hold limit, varying uart busy time
        stall_max = 4; l_min = 1; l_max = 5;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                npk = $urandom_range(3, 0);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(4, 1);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), 1'(b == len - 1));
                end
            end
            wait_idle("rnd_idle", 3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte transmitter between `N` byte-stream requesters, such as the CPU port, a debug monitor and the packet framer. It sits between the requesters and the `tx_strobe`/`tx_data`/`tx_ready` pins of `uart`/`uart_tx`. It grants the transmitter to one requester for a whole packet, which ends at `req_last`, so bytes from different sources never interleave. An idle-hold timeout releases the lock if the owner stalls mid-packet.

## Interface
- `N`, default 4: number of requesters; legal range 2..8.
- `HOLD_CYCLES`, default 255: consecutive cycles an owner may hold the lock with `req_valid` low before the lock is released; legal range 1..65535.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `req_valid`  input  N  requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  input  8N  packed byte lanes.
- `req_last`  input  N  the offered byte is the final byte of the packet.
- `req_ready`  output  N  combinational accept; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `grant`  output  N  one-hot owner, registered; all zero when no requester owns the transmitter.
- `busy`  output  1  registered; state != IDLE.
- `tx_data`  output  8  registered byte to `uart_tx`.
- `tx_strobe`  output  1  registered single-cycle load pulse to `uart_tx`.
- `tx_ready`  input  1  `uart_tx` idle/ready; treated as a level.

## Operation
- Reset values: state IDLE, `grant`=0, `busy`=0, `tx_strobe`=0, `tx_data`=0x00, round-robin pointer=0, hold counter=0, latched last=0.
- Round robin: search order starts at the pointer and wraps modulo N. The first index with `req_valid` set wins. When a lock is released, the pointer becomes (owner+1) mod N.
- State IDLE: when `tx_ready` is high and any `req_valid` is set, latch the winner into `grant` and go to ISSUE. `req_ready` is 0 in IDLE.
- State ISSUE:
  - `req_ready[owner] = tx_ready`; every other `req_ready` bit is 0.
  - On a transfer: `tx_data <= req_data[owner]`, `tx_strobe <= 1` for one cycle, latch `req_last[owner]`, clear the hold counter, go to WAIT_ACK.
  - Without a transfer while `req_valid[owner]` is low: increment the hold counter. When the counter reaches `HOLD_CYCLES`, release the lock: go to IDLE, clear `grant`, advance the pointer.
  - The hold counter does not advance while `req_valid[owner]` is high and `tx_ready` is low; the owner is waiting on the transmitter, not stalled.
- State WAIT_ACK: `tx_strobe` has returned to 0. Stay until `tx_ready` is sampled low, which confirms that `uart_tx` loaded the byte. Then:
  - if the latched last bit is set, go to IDLE, clear `grant` and advance the pointer;
  - otherwise return to ISSUE.
  - There is no timeout in this state; it waits indefinitely.
- Requesters other than the owner are never accepted mid-packet, even if they are valid.
- `req_data` and `req_last` of the owner need only be stable on the transfer cycle.
- Width rules: the hold counter is 16 bits and saturates at `HOLD_CYCLES`. The pointer and owner index are `$clog2(N)` bits. Index wrap uses an explicit compare against N-1, so non-power-of-2 N is legal.

## Timing
- Single-byte packet, IDLE, `tx_ready`=1, request at cycle 0:
  - `grant` set at cycle 1, with `req_ready` high in cycle 1 and the transfer in cycle 1;
  - `tx_strobe` high in cycle 2;
  - `uart_tx` drops `tx_ready` in cycle 3;
  - IDLE with `grant`=0 in cycle 4.
- Back-to-back bytes within a packet: the next accept comes no earlier than the first cycle after `tx_ready` has gone low and returned high. Byte throughput is bounded by the UART, never by the arbiter.
- At most one `tx_strobe` is issued per low-going `tx_ready` excursion; there is never a second strobe while the shift register is loaded.
- Reset asserted mid-operation: all state returns to reset values immediately, any pending `tx_strobe` is dropped, and a byte already inside `uart_tx` is unaffected.
- Simultaneous last-byte completion and a new request: the release takes effect first. The new winner is chosen in IDLE on the following cycle using the advanced pointer.

## Test plan
- Reset, then `req_valid`=0001 with one byte 0x55 and last=1: one `tx_strobe` carrying 0x55 in cycle 2, `grant` 0001→0000, `req_ready[0]` high for exactly one cycle.
- All four requesters valid with single-byte packets 0xA0..0xA3: strobes occur in order 0xA0, 0xA1, 0xA2, 0xA3; a repeat round keeps the same order, confirming the pointer wraps 3→0.
- Requester 1 sends a 3-byte packet 0x10, 0x11, 0x12 while requester 0 is continuously valid: all three bytes go out contiguously; requester 0 is granted only after 0x12 is acknowledged.
- With `HOLD_CYCLES`=4, the owner sends one non-last byte and then drops `req_valid`: `grant` clears after exactly 4 ISSUE cycles; requester 2, which is waiting, is granted next.
- Hold `tx_ready` at 0 externally for 100 cycles with the owner valid: no strobe, no hold-counter release, `req_ready`=0. When `tx_ready` is released, a transfer occurs the same cycle.
- Assert `reset` in WAIT_ACK and in ISSUE: outputs reach their reset values without a clock edge. The first post-reset grant goes to the lowest valid index.
